// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load/bubble/hold decode, flush, and stall watchdog.
// Optional perf counters (perf_bubbles, perf_holds) are enabled by defining ID_EX_PERF_EN.
module id_ex_stage_reg #(
  parameter int CTRL_W    = 12,
  parameter int STALL_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        ID_EX_Write,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [5:0]        id_opcode,
  input  logic [5:0]        id_func,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic [31:0]       id_imm_ext,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_write_reg,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_rs_data,
  output logic [31:0]       ex_rt_data,
  output logic [31:0]       ex_imm_ext,
  output logic [5:0]        ID_EXE_opcode,
  output logic [5:0]        ex_func,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ID_EXE_WriteReg,
`ifdef ID_EX_PERF_EN
  output logic [31:0]       perf_bubbles,
  output logic [31:0]       perf_holds,
`endif
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              stall_timeout
);
  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [5:0]        opcode;
    logic [5:0]        func;
    logic [31:0]       rs_data;
    logic [31:0]       rt_data;
    logic [31:0]       imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        wr;
    logic [CTRL_W-1:0] ctrl;
  } stage_t;
  localparam logic [7:0] STALL_LIM = 8'(STALL_MAX);
  stage_t     stage_q, stage_d, id_s;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;
  logic       load, nop, hold;
  // An all-zero bundle is the NOP: sll $0 with no writes enabled.
  assign nop  = flush || (ID_EX_Write == 3'b000);
  assign load = !nop && (ID_EX_Write == 3'b111);
  assign hold = !nop && !load;
  always_comb begin
    id_s = '{valid: id_valid, pc: id_pc, opcode: id_opcode, func: id_func,
             rs_data: id_rs_data, rt_data: id_rt_data, imm: id_imm_ext,
             rs: id_rs, rt: id_rt, wr: id_write_reg, ctrl: id_ctrl};
    stage_d = nop ? '0 : load ? id_s : stage_q;
    hold_cnt_d = !hold ? 8'd0 :
                 (stage_q.valid && hold_cnt_q != 8'hFF) ? hold_cnt_q + 8'd1 : hold_cnt_q;
    timeout_d = timeout_q || (hold_cnt_d >= STALL_LIM);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q    <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      stage_q    <= stage_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
`ifdef ID_EX_PERF_EN
  logic [31:0] bubbles_q, bubbles_d, holds_q, holds_d;
  always_comb begin
    bubbles_d = (nop && bubbles_q != '1) ? bubbles_q + 32'd1 : bubbles_q;
    holds_d   = (hold && holds_q != '1) ? holds_q + 32'd1 : holds_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bubbles_q <= '0;
      holds_q   <= '0;
    end else begin
      bubbles_q <= bubbles_d;
      holds_q   <= holds_d;
    end
  end
  assign perf_bubbles = bubbles_q;
  assign perf_holds   = holds_q;
`endif
  assign ex_valid        = stage_q.valid;
  assign ex_pc           = stage_q.pc;
  assign ex_rs_data      = stage_q.rs_data;
  assign ex_rt_data      = stage_q.rt_data;
  assign ex_imm_ext      = stage_q.imm;
  assign ID_EXE_opcode   = stage_q.opcode;
  assign ex_func         = stage_q.func;
  assign ex_rs           = stage_q.rs;
  assign ex_rt           = stage_q.rt;
  assign ID_EXE_WriteReg = stage_q.wr;
  assign ex_ctrl         = stage_q.ctrl;
  assign stall_timeout   = timeout_q;
endmodule
